// File: rtl/flag_fifo.sv
// flag_fifo
// ---------
// Multi-entry successor to the single-entry flag buffer. Words pushed with
// i_set_flag are held in arrival order, and i_clr_flag pops the oldest one.
// The head word is always presented on o_dout, so the read is first-word
// fall-through.
//
// Parameters
//   W      data width in bits
//   DEPTH  number of entries (power of 2, at least 2)
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-low reset
//   i_set_flag  push strobe, writes i_din
//   i_clr_flag  pop strobe, removes the oldest word
//   i_din       write data
//   i_clr_ovr   clears the sticky overrun flag
//   o_flag      FIFO not empty
//   o_dout      oldest stored word, 0 when empty
//   o_full      count == DEPTH
//   o_count     number of stored words, 0..DEPTH
//   o_overrun   sticky: a push was dropped because the FIFO was full
module flag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_set_flag,
  input  logic                       i_clr_flag,
  input  logic [W-1:0]               i_din,
  input  logic                       i_clr_ovr,
  output logic                       o_flag,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overrun
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overrun;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop on an empty FIFO is ignored. A push into a full FIFO is accepted
  // only when a pop in the same cycle frees the head slot.
  assign do_pop  = i_clr_flag && !empty;
  assign do_push = i_set_flag && (!full || do_pop);

  // Storage is not reset; o_dout is masked while empty, so stale contents
  // never reach the output.
  always_ff @(posedge i_clk) begin
    if (i_reset && do_push) begin
      mem[wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2. The count is kept
  // separately so that full and empty are distinguishable when pointers match.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      // A dropped push takes precedence over a clear in the same cycle.
      if (i_set_flag && !do_push) begin
        overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign o_flag    = !empty;
  assign o_full    = full;
  assign o_count   = count;
  assign o_overrun = overrun;
  assign o_dout    = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_flag_fifo.sv
// tb_flag_fifo
// ------------
// Self-checking bench for flag_fifo with W=8 and DEPTH=4. A table of
// single-cycle vectors holds the inputs for each edge and the outputs
// expected just after it. Short hand-written sequences cover pointer wrap
// and simultaneous push/pop with the FIFO partly filled.
module tb_flag_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         set_flag;
  logic         clr_flag;
  logic [W-1:0] din;
  logic         clr_ovr;
  logic         flag;
  logic [W-1:0] dout;
  logic         full;
  logic [2:0]   count;
  logic         overrun;

  int checks;
  int errors;

  typedef struct {
    string      tag;
    logic       rst_n;
    logic       set;
    logic       clr;
    logic       clr_ovr;
    logic [7:0] din;
    logic       flag;
    logic [7:0] dout;
    logic       full;
    logic [2:0] count;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  flag_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_set_flag (set_flag),
    .i_clr_flag (clr_flag),
    .i_din      (din),
    .i_clr_ovr  (clr_ovr),
    .o_flag     (flag),
    .o_dout     (dout),
    .o_full     (full),
    .o_count    (count),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Appends one vector: inputs for the edge, then outputs expected after it.
  task automatic addVec(input string tag, input logic r, input logic s,
                        input logic c, input logic co, input logic [7:0] d,
                        input logic ef, input logic [7:0] ed, input logic efu,
                        input logic [2:0] ec, input logic eo);
    vec_t v;
    v.tag = tag; v.rst_n = r; v.set = s; v.clr = c; v.clr_ovr = co; v.din = d;
    v.flag = ef; v.dout = ed; v.full = efu; v.count = ec; v.ovr = eo;
    vecs.push_back(v);
  endtask

  // Drives inputs on the falling edge and samples 1 ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic c,
                               input logic co, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; set_flag = s; clr_flag = c; clr_ovr = co; din = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1; set_flag = 1'b0; clr_flag = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic ef,
                             input logic [7:0] ed, input logic efu,
                             input logic [2:0] ec, input logic eo);
    checks++;
    if (flag !== ef || dout !== ed || full !== efu || count !== ec ||
        overrun !== eo) begin
      errors++;
      $display("[TB] FAIL %s: got flag=%0b dout=%02h full=%0b count=%0d ovr=%0b, want flag=%0b dout=%02h full=%0b count=%0d ovr=%0b",
               tag, flag, dout, full, count, overrun, ef, ed, efu, ec, eo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1; set_flag = 1'b0; clr_flag = 1'b0; clr_ovr = 1'b0; din = '0;

    //     tag            rst set clr cov din     flag dout  full cnt ovr
    addVec("reset",        0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0);
    addVec("push_a1",      1, 1, 0, 0, 8'hA1,  1, 8'hA1, 0, 1, 0);
    addVec("pop_a1",       1, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0);
    addVec("fill_11",      1, 1, 0, 0, 8'h11,  1, 8'h11, 0, 1, 0);
    addVec("fill_22",      1, 1, 0, 0, 8'h22,  1, 8'h11, 0, 2, 0);
    addVec("fill_33",      1, 1, 0, 0, 8'h33,  1, 8'h11, 0, 3, 0);
    addVec("fill_44",      1, 1, 0, 0, 8'h44,  1, 8'h11, 1, 4, 0);
    addVec("overflow_55",  1, 1, 0, 0, 8'h55,  1, 8'h11, 1, 4, 1);
    addVec("pop_11",       1, 0, 1, 0, 8'h00,  1, 8'h22, 0, 3, 1);
    addVec("pop_22",       1, 0, 1, 0, 8'h00,  1, 8'h33, 0, 2, 1);
    addVec("pop_33",       1, 0, 1, 0, 8'h00,  1, 8'h44, 0, 1, 1);
    addVec("pop_44",       1, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 1);
    addVec("clr_ovr",      1, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0);
    addVec("refill_11",    1, 1, 0, 0, 8'h11,  1, 8'h11, 0, 1, 0);
    addVec("refill_22",    1, 1, 0, 0, 8'h22,  1, 8'h11, 0, 2, 0);
    addVec("refill_33",    1, 1, 0, 0, 8'h33,  1, 8'h11, 0, 3, 0);
    addVec("refill_44",    1, 1, 0, 0, 8'h44,  1, 8'h11, 1, 4, 0);
    addVec("full_pushpop", 1, 1, 1, 0, 8'h66,  1, 8'h22, 1, 4, 0);
    addVec("pop_22b",      1, 0, 1, 0, 8'h00,  1, 8'h33, 0, 3, 0);
    addVec("pop_33b",      1, 0, 1, 0, 8'h00,  1, 8'h44, 0, 2, 0);
    addVec("pop_44b",      1, 0, 1, 0, 8'h00,  1, 8'h66, 0, 1, 0);
    addVec("pop_66",       1, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0);
    addVec("empty_pushpop",1, 1, 1, 0, 8'h77,  1, 8'h77, 0, 1, 0);
    addVec("pop_77",       1, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0);
    addVec("pop_empty",    1, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0);
    addVec("fill_a0",      1, 1, 0, 0, 8'hA0,  1, 8'hA0, 0, 1, 0);
    addVec("fill_a1",      1, 1, 0, 0, 8'hA1,  1, 8'hA0, 0, 2, 0);
    addVec("fill_a2",      1, 1, 0, 0, 8'hA2,  1, 8'hA0, 0, 3, 0);
    addVec("fill_a3",      1, 1, 0, 0, 8'hA3,  1, 8'hA0, 1, 4, 0);
    addVec("ovr_beats_clr",1, 1, 0, 1, 8'hB0,  1, 8'hA0, 1, 4, 1);
    addVec("clr_ovr_alone",1, 0, 0, 1, 8'h00,  1, 8'hA0, 1, 4, 0);
    addVec("pop_a0",       1, 0, 1, 0, 8'h00,  1, 8'hA1, 0, 3, 0);
    addVec("reset_w_push", 0, 1, 0, 0, 8'hC0,  0, 8'h00, 0, 0, 0);
    addVec("post_rst_d0",  1, 1, 0, 0, 8'hD0,  1, 8'hD0, 0, 1, 0);
    addVec("post_rst_pop", 1, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].set, vecs[i].clr, vecs[i].clr_ovr,
                    vecs[i].din);
      checkOutput(vecs[i].tag, vecs[i].flag, vecs[i].dout, vecs[i].full,
                  vecs[i].count, vecs[i].ovr);
    end

    // Pointer wrap: ten push/pop pairs carry both pointers around the ring
    // more than twice; occupancy never goes above one.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
      checkOutput($sformatf("wrap_push_%0d", i), 1'b1, 8'(i), 1'b0, 3'd1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("wrap_pop_%0d", i), 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    end

    // Partly filled push+pop: count holds while the head advances.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
    checkOutput("mid_push_10", 1'b1, 8'h10, 1'b0, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
    checkOutput("mid_push_20", 1'b1, 8'h10, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h30);
    checkOutput("mid_pushpop", 1'b1, 8'h20, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("mid_pop_20", 1'b1, 8'h30, 1'b0, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("mid_pop_30", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_fifo.md
Name: flag_fifo

Overview:
- Parametrised successor to the single-entry flag buffer.
- Holds up to DEPTH words of W bits in arrival order, so a producer such as UART RX can deliver several words before the consumer reads any.
- Keeps the same set/clear strobe interface (set = push, clear = pop).
- Adds a full indication, an occupancy count, and a sticky overrun flag.

Parameters:
- W, 8, data width in bits.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- ADDR_W, log2(DEPTH), pointer width; derived localparam, not overridable.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of i_clk.
- i_set_flag  input  1  push strobe; writes i_din into the FIFO.
- i_clr_flag  input  1  pop strobe; removes the oldest word.
- i_din  input  W  write data, sampled when i_set_flag=1.
- i_clr_ovr  input  1  clears o_overrun.
- o_flag  output  1  1 while the FIFO is not empty.
- o_dout  output  W  oldest stored word (first-word fall-through); 0 when empty.
- o_full  output  1  1 when count == DEPTH.
- o_count  output  ADDR_W+1  number of stored words, 0..DEPTH.
- o_overrun  output  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (i_reset=0 at a rising edge):
  - Read pointer, write pointer, count and overrun are cleared.
  - Outputs: o_flag=0, o_full=0, o_count=0, o_overrun=0, o_dout=0.
  - Storage array is not cleared; it is not observable because o_dout is forced to 0 while empty.
  - Reset overrides every other input in the same cycle, including mid-burst pushes and pops.
- Storage and pointers:
  - Storage is a DEPTH x W register array.
  - Write and read pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
  - Count is a separate ADDR_W+1-bit register.
- Push only (set=1, clr=0):
  - If not full: mem[wr_ptr] <= i_din, wr_ptr++, count++.
  - If full: data is dropped; pointers and count are unchanged; o_overrun <= 1.
- Pop only (set=0, clr=1):
  - If not empty: rd_ptr++, count--.
  - If empty: ignored; no state change and no error flag.
- Push and pop in the same cycle:
  - Empty: push is performed, pop is ignored; count becomes 1.
  - Not empty and not full: both are performed; count is unchanged.
  - Full: both are performed; the pop frees the slot, so the push is accepted, count stays DEPTH, and no overrun is flagged.
- Latency:
  - A word pushed at edge N is visible on o_dout with o_flag=1 after edge N (one cycle).
  - After a pop at edge N, o_dout shows the next word after edge N.
- Output decode: all outputs are derived combinationally from registers only; there are no combinational paths from any input to any output.
  - o_flag = (count != 0)
  - o_full = (count == DEPTH)
  - o_dout = o_flag ? mem[rd_ptr] : 0
- Overrun flag:
  - Sticky; cleared only by i_clr_ovr=1 or by reset.
  - If a dropped push and i_clr_ovr occur in the same cycle, set wins.
- Write order: strict FIFO. No word is ever duplicated, reordered or lost, except for pushes dropped while full.

Test Plan:
- Reset, then push 0xA1 -> one cycle later o_flag=1, o_dout=0xA1, o_count=1; pop -> o_flag=0, o_dout=0x00, o_count=0.
- Push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) -> o_full=1, o_count=4; fifth push 0x55 -> o_overrun=1, count stays 4; four pops return 0x11, 0x22, 0x33, 0x44 in order.
- With FIFO full, assert push 0x66 and pop together -> o_overrun stays 0, o_count=4; the next four pops yield 0x22, 0x33, 0x44, 0x66.
- With FIFO empty, assert push 0x77 and pop together -> o_count=1, o_dout=0x77; pop on empty FIFO -> count stays 0, no flags change.
- Pointer wrap: perform 10 push/pop pairs of 0x00..0x09 -> each value read back in order; o_count never exceeds 1.
- Overrun flag precedence: drive i_clr_ovr=1 in the same cycle as an overflow push -> o_overrun=1; next cycle i_clr_ovr=1 alone -> o_overrun=0.
- Reset mid-operation: hold 3 words, drive i_reset=0 for one edge together with a push -> o_count=0, o_flag=0, o_full=0, o_overrun=0, o_dout=0.
